// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

   // Capture state machine states.
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      CAPTURE  = 2'd1,
      PAD      = 2'd2
   } i2s_state_e;

   localparam int   I2S_DATA_W_DEFAULT = 24;

   // Channel encoding follows the lrclk level: 0 = left, 1 = right.
   localparam logic I2S_CH_L = 1'b0;
   localparam logic I2S_CH_R = 1'b1;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchronizer for the asynchronous I2S pins.
// Bit edge_in gets a history flop and a rising-edge pulse; data_in only
// goes through the plain synchronizer path, with the same depth so that
// data and the detected edge stay aligned.
module i2s_sync #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             edge_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             rise,
   output logic [WIDTH-1:0] data_out
);

   // Bit 0 carries the edge-detected signal, the upper bits carry data.
   logic [WIDTH:0] stage_r [STAGES];
   logic           hist_r;

   // Synchronizer chain plus one history flop on the edge-detected bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_r[i] <= '0;
         end
         hist_r <= 1'b0;
      end else begin
         stage_r[0] <= {data_in, edge_in};
         for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
         hist_r <= stage_r[STAGES-1][0];
      end
   end

   assign rise     = stage_r[STAGES-1][0] & ~hist_r;
   assign data_out = stage_r[STAGES-1][WIDTH:1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receive deserializer: aligns to the left-channel boundary, captures
// DATA_W bits per slot MSB first and presents left/right pairs through a
// valid/ready handshake with sticky overrun and short-slot error flags.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int DATA_W      = I2S_DATA_W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              bclk,
   input  logic              lrclk,
   input  logic              sdata,
   output logic [DATA_W-1:0] out_l,
   output logic [DATA_W-1:0] out_r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              locked,
   output logic              overrun,
   output logic              frame_err
);

   localparam int              CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic              rise_s;
   logic [1:0]        pins_s;
   logic              lr_s;
   logic              d_s;
   logic              pair_s;

   i2s_state_e        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] shreg_r;
   logic [DATA_W-1:0] hold_l_r;
   logic              have_l_r;
   logic              ch_r;
   logic              lr_prev_r;
   logic              split_r;
   logic              nxt_ch_r;
   logic              locked_r;
   logic              frame_err_r;
   logic [DATA_W-1:0] out_l_r;
   logic [DATA_W-1:0] out_r_r;
   logic              out_valid_r;
   logic              overrun_r;

   i2s_sync #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (2)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .edge_in  (bclk),
      .data_in  ({sdata, lrclk}),
      .rise     (rise_s),
      .data_out (pins_s)
   );

   assign lr_s = pins_s[0];
   assign d_s  = pins_s[1];

   // A pair is ready when a right word completes after a completed left word.
   always_comb begin
      pair_s = 1'b0;
      if (en && (state_r == CAPTURE) && (cnt_r == CNT_FULL) &&
          (ch_r == I2S_CH_R) && have_l_r) begin
         pair_s = 1'b1;
      end else begin
         pair_s = 1'b0;
      end
   end

   // Alignment, bit capture and word completion state machine.
   // With slots of exactly DATA_W bclks the LSB of a word arrives on the
   // first rise of the next slot (the I2S one-bit delay). A boundary seen
   // with exactly one bit missing therefore takes that bit, completes the
   // word, and remembers the new channel in nxt_ch_r for the cycle after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= UNLOCKED;
         cnt_r       <= CNT_ZERO;
         shreg_r     <= '0;
         hold_l_r    <= '0;
         have_l_r    <= 1'b0;
         ch_r        <= I2S_CH_L;
         lr_prev_r   <= 1'b0;
         split_r     <= 1'b0;
         nxt_ch_r    <= I2S_CH_L;
         locked_r    <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         if (rise_s) begin
            lr_prev_r <= lr_s;
         end
         if (!en) begin
            state_r  <= UNLOCKED;
            cnt_r    <= CNT_ZERO;
            have_l_r <= 1'b0;
            split_r  <= 1'b0;
            locked_r <= 1'b0;
         end else begin
            case (state_r)
               UNLOCKED: begin
                  locked_r <= 1'b0;
                  if (rise_s && (lr_prev_r == 1'b1) && (lr_s == 1'b0)) begin
                     state_r  <= CAPTURE;
                     cnt_r    <= CNT_ZERO;
                     ch_r     <= I2S_CH_L;
                     split_r  <= 1'b0;
                     locked_r <= 1'b1;
                  end
               end
               CAPTURE: begin
                  if (cnt_r == CNT_FULL) begin
                     if (ch_r == I2S_CH_L) begin
                        hold_l_r <= shreg_r;
                        have_l_r <= 1'b1;
                     end else begin
                        have_l_r <= 1'b0;
                     end
                     if (split_r) begin
                        state_r <= CAPTURE;
                        cnt_r   <= CNT_ZERO;
                        ch_r    <= nxt_ch_r;
                        split_r <= 1'b0;
                     end else begin
                        state_r <= PAD;
                     end
                  end else if (rise_s) begin
                     if (lr_s == lr_prev_r) begin
                        shreg_r <= {shreg_r[DATA_W-2:0], d_s};
                        cnt_r   <= cnt_r + CNT_ONE;
                     end else if (cnt_r == CNT_LAST) begin
                        shreg_r  <= {shreg_r[DATA_W-2:0], d_s};
                        cnt_r    <= cnt_r + CNT_ONE;
                        split_r  <= 1'b1;
                        nxt_ch_r <= lr_s;
                     end else begin
                        frame_err_r <= 1'b1;
                        have_l_r    <= 1'b0;
                        ch_r        <= lr_s;
                        cnt_r       <= CNT_ZERO;
                     end
                  end
               end
               PAD: begin
                  if (rise_s && (lr_s != lr_prev_r)) begin
                     state_r <= CAPTURE;
                     ch_r    <= lr_s;
                     cnt_r   <= CNT_ZERO;
                  end
               end
               default: begin
                  state_r  <= UNLOCKED;
                  locked_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // Output pair register with valid/ready handshake and sticky overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_l_r     <= '0;
         out_r_r     <= '0;
         out_valid_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else if (pair_s) begin
         if (!out_valid_r || out_ready) begin
            out_l_r     <= hold_l_r;
            out_r_r     <= shreg_r;
            out_valid_r <= 1'b1;
         end else begin
            overrun_r <= 1'b1;
         end
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_l     = out_l_r;
   assign out_r     = out_r_r;
   assign out_valid = out_valid_r;
   assign locked    = locked_r;
   assign overrun   = overrun_r;
   assign frame_err = frame_err_r;

endmodule
